// File: rtl/muldiv_seq.sv
// muldiv_seq - multi-cycle RV32M multiply/divide unit for the execute stage.
//
// One request per start/ready handshake. Multiplies use shift-add on a
// 2*XLEN accumulator and divides use restoring division, one bit per cycle.
// Division by zero and signed overflow complete without iterating.
//
// Optional build macro:
//   MULDIV_FAST_MUL_EN - multiplies use a single-cycle combinational product
//                        at acceptance; division remains iterative.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_n_i   asynchronous active-low reset
//   start_i   request, accepted only while ready_o=1
//   op_i      funct3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   data_a_i  rs1 (multiplicand / dividend)
//   data_b_i  rs2 (multiplier / divisor)
//   flush_i   abort the in-flight operation (priority over start_i)
//   ready_o   unit idle, can accept a request
//   valid_o   one-cycle pulse, result_o carries a new result
//   result_o  registered result, held until the next valid_o
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] data_a_i,
  input  logic [XLEN-1:0] data_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {-, quotient}
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     opd_q, opd_d;     // multiplicand or divisor magnitude
  logic                neg_q, neg_d;     // negate the final result
  logic [XLEN-1:0]     res_q, res_d;     // finished result awaiting publication
  logic [XLEN-1:0]     result_q, result_d;
  logic                valid_q, valid_d;

  logic                rdy;
  logic                sa, sb, b_zero, ovf, pre_neg;
  logic [XLEN-1:0]     abs_a, abs_b, pre_opd, pre_low;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN+1:0]     rem_sh, div_diff;
  logic [XLEN:0]       rem_next;
  logic [XLEN-1:0]     quot_next, div_sel, div_fin, calc_fin;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fast_prod;
`endif

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] prod,
                                               input logic             neg,
                                               input logic [1:0]       sel);
    logic [2*XLEN-1:0] fixed;
    fixed = neg ? ('0 - prod) : prod;
    return (sel == 2'b00) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  endfunction

  // valid_o is published one cycle after DONE so that a flush seen during
  // DONE can still suppress it without a combinational path to the outputs.
  assign rdy      = (state_q == S_IDLE) && !valid_q;
  assign ready_o  = rdy;
  assign valid_o  = valid_q;
  assign result_o = result_q;

  // Operand preparation at acceptance.
  always_comb begin
    sa      = data_a_i[XLEN-1];
    sb      = data_b_i[XLEN-1];
    abs_a   = sa ? ('0 - data_a_i) : data_a_i;
    abs_b   = sb ? ('0 - data_b_i) : data_b_i;
    pre_opd = data_a_i;
    pre_low = data_b_i;
    pre_neg = 1'b0;
    case (op_i)
      3'b001: begin pre_opd = abs_a;    pre_low = abs_b;    pre_neg = sa ^ sb; end
      3'b010: begin pre_opd = abs_a;                        pre_neg = sa;      end
      3'b100: begin pre_opd = abs_b;    pre_low = abs_a;    pre_neg = sa ^ sb; end
      3'b101: begin pre_opd = data_b_i; pre_low = data_a_i;                    end
      3'b110: begin pre_opd = abs_b;    pre_low = abs_a;    pre_neg = sa;      end
      3'b111: begin pre_opd = data_b_i; pre_low = data_a_i;                    end
      default: ;
    endcase
    b_zero = (data_b_i == '0);
    ovf    = !op_i[0] && (data_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (data_b_i == '1);
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, pre_opd} * {{XLEN{1'b0}}, pre_low};
`endif
  end

  // One iteration step plus the sign-corrected result of that step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh    = {rem_q, acc_q[XLEN-1]};
    div_diff  = rem_sh - {2'b00, opd_q};
    rem_next  = div_diff[XLEN+1] ? rem_sh[XLEN:0] : div_diff[XLEN:0];
    quot_next = {acc_q[XLEN-2:0], ~div_diff[XLEN+1]};
    div_sel   = op_q[1] ? rem_next[XLEN-1:0] : quot_next;
    div_fin   = neg_q ? ('0 - div_sel) : div_sel;
    calc_fin  = op_q[2] ? div_fin : mul_pick(mul_next, neg_q, op_q[1:0]);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opd_d    = opd_q;
    neg_d    = neg_q;
    res_d    = res_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && rdy) begin
          op_d    = op_i;
          opd_d   = pre_opd;
          acc_d   = {{XLEN{1'b0}}, pre_low};
          rem_d   = '0;
          neg_d   = pre_neg;
          cnt_d   = CNT_W'(XLEN);
          state_d = S_CALC;
          if (op_i[2] && b_zero) begin
            res_d   = op_i[1] ? data_a_i : '1;
            state_d = S_DONE;
          end else if (op_i[2] && ovf) begin
            res_d   = op_i[1] ? '0 : data_a_i;
            state_d = S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!op_i[2]) begin
            res_d   = mul_pick(fast_prod, pre_neg, op_i[1:0]);
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], quot_next};
          rem_d = rem_next;
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = calc_fin;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        valid_d  = 1'b1;
        result_d = res_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opd_q    <= opd_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq - self-checking bench for muldiv_seq (XLEN=32): directed
// cases, corner-biased random operations with busy-time noise, flush and
// asynchronous reset, checked against a plain-arithmetic reference model.
module tb_muldiv_seq;
  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        ready, valid;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .op_i     (op),
    .data_a_i (a),
    .data_b_i (b),
    .flush_i  (flush),
    .ready_o  (ready),
    .valid_o  (valid),
    .result_o (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [63:0] sx, sy, uy, p;
    logic [63:0]        pu;
    logic [31:0]        r;
    logic               of;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    uy = {32'h0, y};
    of = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'b000: begin p = sx * sy; r = p[31:0]; end
      3'b001: begin p = sx * sy; r = p[63:32]; end
      3'b010: begin p = sx * uy; r = p[63:32]; end
      3'b011: begin pu = {32'h0, x} * {32'h0, y}; r = pu[63:32]; end
      3'b100: r = (y == 0) ? 32'hFFFF_FFFF : of ? x : 32'($signed(x) / $signed(y));
      3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: r = (y == 0) ? x : of ? 32'h0 : 32'($signed(x) % $signed(y));
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int unsigned ref_lat(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation at the current negedge (unit must be ready) and
  // follow it to completion. With noise set, start_i and the operand/op
  // inputs toggle randomly while the unit is busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit noise);
    logic [31:0] exp_res;
    int unsigned exp_lat;
    int unsigned c;
    bit          seen;
    exp_res = ref_model(o, x, y);
    exp_lat = ref_lat(o, x, y);
    check("ready_before_start", {31'h0, ready}, 32'h1);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    check("ready_low_after_accept", {31'h0, ready}, 32'h0);
    check("valid_low_after_accept", {31'h0, valid}, 32'h0);
    seen = 1'b0;
    c = 1;
    while (!seen && c <= 60) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
      else begin
        c++;
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          op = 3'($urandom); a = $urandom; b = $urandom;
        end
      end
    end
    start = 1'b0;
    check($sformatf("latency op%0d", o), 32'(c), 32'(exp_lat));
    check($sformatf("result op%0d %h %h", o, x, y), result, exp_res);
    last_res = exp_res;
    @(negedge clk);
    check("valid_single_pulse", {31'h0, valid}, 32'h0);
    check("ready_returns", {31'h0, ready}, 32'h1);
    check("result_holds", result, last_res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'h0, ready}, 32'h1);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 1'b0);
    run_op(3'b101, 32'd5, 32'd0, 1'b0);
    run_op(3'b110, 32'd5, 32'd0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush 10 cycles into a DIV, then a new request right away
    start = 1'b1; op = 3'b100; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'h0, ready}, 32'h1);
    check("flush_no_valid", {31'h0, valid}, 32'h0);
    check("flush_result_kept", result, last_res);
    run_op(3'b101, 32'd9, 32'd3, 1'b1);

    // Flush during the DONE cycle of a special-case divide
    start = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_no_valid", {31'h0, valid}, 32'h0);
    check("flush_done_ready", {31'h0, ready}, 32'h1);
    check("flush_done_result_kept", result, last_res);

    // Flush has priority over start in IDLE
    start = 1'b1; flush = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    check("flush_beats_start_valid", {31'h0, valid}, 32'h0);

    // Randomised operations with busy-time noise
    for (int i = 0; i < 48; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), 1'b1);
    end

    // Asynchronous reset in the middle of a MUL
    start = 1'b1; op = 3'b000; a = 32'h1234; b = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", {31'h0, ready}, 32'h1);
    check("async_rst_valid", {31'h0, valid}, 32'h0);
    check("async_rst_result", result, 32'h0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'b000, 32'd6, 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle RV32M-style multiply/divide unit, parametrised in datapath width, placed beside the single-cycle ALU in the execute stage. It accepts one operation per request through a start/ready/valid handshake and iterates one bit per cycle. It handles signed, unsigned and mixed-sign variants, plus the architectural divide-by-zero and overflow cases. The pipeline stalls on `ready_o` low and writes back `result_o` when `valid_o` is high.

## Interface
- `XLEN`, default 32: operand/result width; even, at least 8.
- `CNT_W`, default `$clog2(XLEN)+1`: iteration counter width; derived, do not override.

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `start_i` input 1: request; accepted only when `ready_o`=1.
- `op_i` input 3: funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `data_a_i` input XLEN: rs1 (multiplicand / dividend).
- `data_b_i` input XLEN: rs2 (multiplier / divisor).
- `flush_i` input 1: abort the in-flight operation.
- `ready_o` output 1: unit idle; may accept a new request.
- `valid_o` output 1: `result_o` valid; one-cycle pulse.
- `result_o` output XLEN: registered result; holds until the next `valid_o`.

## Operation
- States:
  - IDLE: `ready_o`=1.
  - CALC: iterating.
  - DONE: `valid_o`=1.
- IDLE→CALC when `start_i`=1 and `flush_i`=0.
  - Latch `op_i` and both operands; later input changes are ignored.
  - Store operand magnitudes and record the result sign.
  - Load the counter with XLEN.
- IDLE→DONE directly for division special cases, result computed at acceptance:
  - DIV/DIVU with b=0: quotient all ones.
  - REM/REMU with b=0: result is a.
  - DIV overflow (a = most negative, b = −1): result is a.
  - REM overflow (same operands): result is 0.
- CALC, multiply: shift-add with a 2·XLEN accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; remainder register XLEN+1 bits.
- Counter decrements each CALC cycle; at 1, transition to DONE.
- On the CALC→DONE edge, apply sign correction (two's complement) and load `result_o`:
  - MUL: low half.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign rules:
  - MULH: negate if sign(a) ≠ sign(b).
  - MULHSU: negate if sign(a); b is unsigned.
  - DIV: negate if sign(a) ≠ sign(b).
  - REM: sign follows the dividend.
  - Unsigned ops never negate.
- DONE→IDLE unconditionally after one cycle.
- `start_i` while `ready_o`=0 is ignored; no queueing.
- `flush_i`=1 in any state: next state IDLE. `valid_o` is not asserted (also suppressed if flush coincides with DONE). `result_o` keeps its previous value. Flush has priority over `start_i`.
- Reset (`rst_n_i` low, any time, including mid-operation):
  - State IDLE, `ready_o`=1, `valid_o`=0, `result_o`=0, counter=0, internal registers 0.

## Timing
- Request accepted at rising edge E0 (`start_i`=1, `ready_o`=1).
- `ready_o` falls in the cycle after E0.
- General case: `valid_o` is high for the single cycle following edge E(XLEN+1), i.e. XLEN+1 cycles after acceptance; `ready_o` returns high the cycle after that.
- Throughput: one operation per XLEN+3 cycles.
- Special-case divisions: `valid_o` high in the cycle following E1, i.e. 1-cycle latency.
- `result_o` and `valid_o` are driven from registers only; no combinational path from inputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - The four multiply ops use a single-cycle combinational 2·XLEN product at acceptance, going IDLE→DONE with 1-cycle latency like the division special cases.
  - Division remains iterative.
- Not defined: all multiplies use the iterative shift-add path with XLEN+1 latency; no hardware multiplier is inferred.

## Test plan
All scenarios use XLEN=32, `MULDIV_FAST_MUL_EN` undefined unless stated.
- MUL, a=7, b=0xFFFFFFFD (−3) → `result_o`=0xFFFFFFEB; `valid_o` pulses exactly 33 cycles after acceptance, for one cycle. Repeat with the macro defined → same result, 1-cycle latency.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, each with `valid_o` 1 cycle after acceptance:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Assert `flush_i` 10 cycles into a DIV → no `valid_o`; `ready_o`=1 the next cycle; `result_o` unchanged. A new DIVU 9/3 accepted immediately → 3. A `start_i` asserted while busy is ignored.
- Drop `rst_n_i` mid-MUL asynchronously → `ready_o`=1, `valid_o`=0, `result_o`=0 before the next clock edge. After release, MUL 6×7 → 42.
